// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 32-bit RISC datapath: FETCH/DECODE/EXEC/MEM/WB
// with memory-ready handshakes, a retire counter and a sticky timeout flag.
module multicycle_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             alu_src,
   output logic [2:0]       alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired,
   output logic             err,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_NOT = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_LDI = 4'b0111;
   localparam logic [3:0] OP_LD  = 4'b1000;
   localparam logic [3:0] OP_SD  = 4'b1010;
   localparam logic [3:0] OP_BNE = 4'b1110;
   localparam logic [3:0] OP_JMP = 4'b1111;

   localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_op;
   logic [7:0]       r_wait;
   logic [CNT_W-1:0] r_retired;
   logic             r_err;
   logic             w_waiting;
   logic             w_ready;
   logic             w_timeout;
   logic             w_nop;
   logic             w_imm;
   logic [2:0]       w_alu_op;

   function automatic logic is_nop(input logic [3:0] op);
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_NOT, OP_SUB,
         OP_LDI, OP_LD, OP_SD, OP_BNE, OP_JMP: is_nop = 1'b0;
         default:                              is_nop = 1'b1;
      endcase
   endfunction

   // The live opcode is only consulted in DECODE; everything later uses r_op.
   assign w_nop = is_nop(opcode);
   assign w_imm = (r_op == OP_LD) || (r_op == OP_SD) || (r_op == OP_LDI);

   always_comb begin
      case (r_op)
         OP_ADD:              w_alu_op = 3'b000;
         OP_SUB:              w_alu_op = 3'b001;
         OP_AND:              w_alu_op = 3'b010;
         OP_NOT:              w_alu_op = 3'b011;
         OP_OR:               w_alu_op = 3'b100;
         OP_JMP:              w_alu_op = 3'b101;
         OP_BNE:              w_alu_op = 3'b111;
         OP_LD, OP_SD, OP_LDI: w_alu_op = 3'b110;
         default:             w_alu_op = 3'b000;
      endcase
   end

   assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_ready   = (r_state == S_FETCH) ? imem_ready : dmem_ready;
   // Ready in the deadline cycle still counts as a normal completion.
   assign w_timeout = w_waiting && !w_ready && (r_wait == WAIT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_op      <= 4'd0;
         r_wait    <= 8'd0;
         r_retired <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_op <= opcode;
         if (w_waiting && !w_ready) r_wait <= r_wait + 8'd1;
         else                       r_wait <= 8'd0;
         if (instr_done) r_retired <= r_retired + CNT_ONE;
         if (w_timeout)  r_err <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (imem_ready)     w_next = S_DECODE;
            else if (w_timeout) w_next = S_ERR;
         end
         S_DECODE: w_next = w_nop ? S_FETCH : S_EXEC;
         S_EXEC: begin
            case (r_op)
               OP_JMP, OP_BNE: w_next = S_FETCH;
               OP_LD, OP_SD:   w_next = S_MEM;
               default:        w_next = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ready)     w_next = (r_op == OP_LD) ? S_WB : S_FETCH;
            else if (w_timeout) w_next = S_ERR;
         end
         S_WB:    w_next = S_FETCH;
         S_ERR:   w_next = S_ERR;
         default: w_next = S_FETCH;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 3'b000;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            S_DECODE: instr_done = w_nop;
            S_EXEC: begin
               alu_op  = w_alu_op;
               alu_src = w_imm;
               if (r_op == OP_JMP) begin
                  pc_write   = 1'b1;
                  pc_src     = 1'b1;
                  instr_done = 1'b1;
               end else if (r_op == OP_BNE) begin
                  pc_write   = ~zero;
                  pc_src     = 1'b1;
                  instr_done = 1'b1;
               end
            end
            S_MEM: begin
               alu_op     = w_alu_op;
               alu_src    = w_imm;
               mem_read   = (r_op == OP_LD);
               mem_write  = (r_op == OP_SD);
               instr_done = dmem_ready && (r_op == OP_SD);
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (r_op == OP_LD);
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign err     = r_err & ~reset;
   assign retired = reset ? '0 : r_retired;
   assign state_o = reset ? 3'd0 : r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-instruction
// expectations, a negedge monitor checks them on every retire pulse.
module tb_multicycle_ctrl;

   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [3:0]       opcode = 4'd0;
   logic             zero = 1'b0;
   logic             imem_ready = 1'b0;
   logic             dmem_ready = 1'b0;
   logic             imem_req, ir_write, pc_write, pc_src, alu_src;
   logic [2:0]       alu_op;
   logic             mem_read, mem_write, mem_to_reg, reg_write, instr_done;
   logic [CNT_W-1:0] retired;
   logic             err;
   logic [2:0]       state_o;

   multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .instr_done(instr_done), .retired(retired),
      .err(err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0] op;
      int         cyc;
      logic [7:0] path;
      logic [3:0] ret;
      logic       exec;
      logic [2:0] alu_op;
      int n_imem, n_irw, n_pcw, n_pcsrc, n_alusrc, n_rd, n_wr, n_m2r, n_rw;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] model_ret = 4'd0;

   wire [12:0] strobes = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
                          mem_read, mem_write, mem_to_reg, reg_write, instr_done};
   wire [20:0] all_out = {strobes, retired, err, state_o};

   // Monitor: accumulates what the DUT did since the last retire.
   int         a_cyc, a_imem, a_irw, a_pcw, a_pcsrc, a_alusrc, a_rd, a_wr, a_m2r, a_rw;
   logic [7:0] a_path;
   logic       a_exec;
   logic [2:0] a_aluop;
   exp_t       m_e;

   task automatic mon_clear();
      a_cyc = 0; a_imem = 0; a_irw = 0; a_pcw = 0; a_pcsrc = 0;
      a_alusrc = 0; a_rd = 0; a_wr = 0; a_m2r = 0; a_rw = 0;
      a_path = 8'd0; a_exec = 1'b0; a_aluop = 3'd0;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         mon_clear();
      end else begin
         a_cyc++;
         a_path    = a_path | (8'd1 << state_o);
         a_imem   += int'(imem_req);
         a_irw    += int'(ir_write);
         a_pcw    += int'(pc_write);
         a_pcsrc  += int'(pc_src);
         a_alusrc += int'(alu_src);
         a_rd     += int'(mem_read);
         a_wr     += int'(mem_write);
         a_m2r    += int'(mem_to_reg);
         a_rw     += int'(reg_write);
         if (state_o == 3'd2) begin
            a_exec  = 1'b1;
            a_aluop = alu_op;
         end
         if (instr_done) begin
            if (sb.size() == 0) begin
               check("unexpected_retire", 32'(state_o), 32'hFFFF_FFFF);
            end else begin
               m_e = sb.pop_front();
               check($sformatf("op%b_cycles", m_e.op), a_cyc, m_e.cyc);
               check($sformatf("op%b_path", m_e.op), 32'(a_path), 32'(m_e.path));
               check($sformatf("op%b_retired", m_e.op), 32'(retired), 32'(m_e.ret));
               check($sformatf("op%b_exec_seen", m_e.op), 32'(a_exec), 32'(m_e.exec));
               if (m_e.exec) check($sformatf("op%b_alu_op", m_e.op), 32'(a_aluop), 32'(m_e.alu_op));
               check($sformatf("op%b_imem_req", m_e.op), a_imem, m_e.n_imem);
               check($sformatf("op%b_ir_write", m_e.op), a_irw, m_e.n_irw);
               check($sformatf("op%b_pc_write", m_e.op), a_pcw, m_e.n_pcw);
               check($sformatf("op%b_pc_src", m_e.op), a_pcsrc, m_e.n_pcsrc);
               check($sformatf("op%b_alu_src", m_e.op), a_alusrc, m_e.n_alusrc);
               check($sformatf("op%b_mem_read", m_e.op), a_rd, m_e.n_rd);
               check($sformatf("op%b_mem_write", m_e.op), a_wr, m_e.n_wr);
               check($sformatf("op%b_mem_to_reg", m_e.op), a_m2r, m_e.n_m2r);
               check($sformatf("op%b_reg_write", m_e.op), a_rw, m_e.n_rw);
            end
            mon_clear();
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      check("reset_outputs_zero", 32'(all_out), 32'd0);
      reset = 1'b0;
      model_ret = 4'd0;
      #1;
      check("reset_state_fetch", 32'(state_o), 32'd0);
      check("reset_retired", 32'(retired), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_imem_req", 32'(imem_req), 32'd1);
   endtask

   // Issues one instruction starting in FETCH: iw FETCH wait cycles, dw MEM
   // wait cycles. Expected counts are per-opcode hand-derived values.
   task automatic run_instr(input logic [3:0] op, input logic z, input int iw, input int dw);
      exp_t e;
      int   lat;
      int   total;
      e = '{default: 0};
      e.op = op;
      e.n_imem = iw + 1;
      e.n_irw  = 1;
      e.n_pcw  = 1;
      lat = 2;
      total = 0;
      case (op)
         4'b0010: begin lat = 4; e.path = 8'b10111; e.exec = 1; e.alu_op = 3'b000; e.n_rw = 1; end
         4'b0110: begin lat = 4; e.path = 8'b10111; e.exec = 1; e.alu_op = 3'b001; e.n_rw = 1; end
         4'b0000: begin lat = 4; e.path = 8'b10111; e.exec = 1; e.alu_op = 3'b010; e.n_rw = 1; end
         4'b0011: begin lat = 4; e.path = 8'b10111; e.exec = 1; e.alu_op = 3'b011; e.n_rw = 1; end
         4'b0001: begin lat = 4; e.path = 8'b10111; e.exec = 1; e.alu_op = 3'b100; e.n_rw = 1; end
         4'b0111: begin
            lat = 4; e.path = 8'b10111; e.exec = 1; e.alu_op = 3'b110;
            e.n_alusrc = 1; e.n_rw = 1;
         end
         4'b1000: begin
            lat = 5 + dw; e.path = 8'b11111; e.exec = 1; e.alu_op = 3'b110;
            e.n_alusrc = dw + 2; e.n_rd = dw + 1; e.n_m2r = 1; e.n_rw = 1;
         end
         4'b1010: begin
            lat = 4 + dw; e.path = 8'b01111; e.exec = 1; e.alu_op = 3'b110;
            e.n_alusrc = dw + 2; e.n_wr = dw + 1;
         end
         4'b1111: begin
            lat = 3; e.path = 8'b00111; e.exec = 1; e.alu_op = 3'b101;
            e.n_pcw = 2; e.n_pcsrc = 1;
         end
         4'b1110: begin
            lat = 3; e.path = 8'b00111; e.exec = 1; e.alu_op = 3'b111;
            e.n_pcw = z ? 1 : 2; e.n_pcsrc = 1;
         end
         default: begin lat = 2; e.path = 8'b00011; end
      endcase
      total = iw + lat;
      e.cyc = total;
      e.ret = model_ret;
      model_ret = model_ret + 4'd1;
      sb.push_back(e);
      for (int i = 0; i < total; i++) begin
         opcode     = op;
         zero       = z;
         imem_ready = (i >= iw);
         dmem_ready = (i >= iw + 3 + dw);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      mon_clear();
      do_reset();

      // add with no waits, then retire count must read 1
      run_instr(4'b0010, 1'b0, 0, 0);
      check("add_retired_after", 32'(retired), 32'd1);

      run_instr(4'b1000, 1'b0, 0, 3);   // ld with 3 MEM wait cycles: 8 cycles
      run_instr(4'b1110, 1'b0, 0, 0);   // bne taken
      run_instr(4'b1110, 1'b1, 0, 0);   // bne not taken
      run_instr(4'b1111, 1'b0, 0, 0);   // jmp
      run_instr(4'b0110, 1'b0, 0, 0);   // sub
      run_instr(4'b0000, 1'b0, 1, 0);   // and with one fetch wait
      run_instr(4'b0001, 1'b0, 0, 0);   // or
      run_instr(4'b0011, 1'b0, 0, 0);   // not
      run_instr(4'b0111, 1'b0, 0, 0);   // ldi
      run_instr(4'b1010, 1'b0, 0, 0);   // sd
      run_instr(4'b1010, 1'b0, 2, 2);   // sd with fetch and mem waits
      run_instr(4'b1000, 1'b0, 2, 0);   // ld with fetch waits
      run_instr(4'b0101, 1'b0, 0, 0);   // nop
      run_instr(4'b1100, 1'b0, 0, 0);   // nop
      check("stream_no_err", 32'(err), 32'd0);

      // FETCH timeout: imem_ready held low for MAX_WAIT cycles
      opcode = 4'b0010; imem_ready = 1'b0; dmem_ready = 1'b0;
      step(); step(); step();
      check("fetch_wait_still_fetch", 32'(state_o), 32'd0);
      check("fetch_wait_no_err", 32'(err), 32'd0);
      step();
      check("fetch_timeout_state", 32'(state_o), 32'd5);
      check("fetch_timeout_err", 32'(err), 32'd1);
      check("fetch_timeout_strobes", 32'(strobes), 32'd0);
      imem_ready = 1'b1; dmem_ready = 1'b1;
      step(); step(); step();
      check("err_held_state", 32'(state_o), 32'd5);
      check("err_held_flag", 32'(err), 32'd1);
      check("err_held_strobes", 32'(strobes), 32'd0);
      do_reset();

      // ready arrives on the deadline cycle: normal completion
      run_instr(4'b0010, 1'b0, MAX_WAIT - 1, 0);
      check("deadline_ready_no_err", 32'(err), 32'd0);

      // MEM timeout on ld
      opcode = 4'b1000; imem_ready = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("mem_wait_state", 32'(state_o), 32'd3);
      check("mem_wait_read", 32'(mem_read), 32'd1);
      step();
      check("mem_timeout_state", 32'(state_o), 32'd5);
      check("mem_timeout_err", 32'(err), 32'd1);
      check("mem_timeout_strobes", 32'(strobes), 32'd0);
      do_reset();

      // 17 nops on a 4-bit counter: wraps 15 -> 0, ends at 1
      for (int i = 0; i < 17; i++) run_instr(4'b0100, 1'b0, 0, 0);
      check("wrap_retired", 32'(retired), 32'd1);

      // reset during MEM of sd
      do_reset();
      opcode = 4'b1010; imem_ready = 1'b1; dmem_ready = 1'b0;
      step(); step(); step();
      check("sd_mem_state", 32'(state_o), 32'd3);
      check("sd_mem_write", 32'(mem_write), 32'd1);
      reset = 1'b1;
      #1;
      check("sd_reset_write_drop", 32'(mem_write), 32'd0);
      check("sd_reset_all_zero", 32'(all_out), 32'd0);
      step();
      reset = 1'b0;
      model_ret = 4'd0;
      #1;
      check("sd_reset_next_fetch", 32'(state_o), 32'd0);
      check("sd_reset_retired", 32'(retired), 32'd0);
      check("sd_reset_err", 32'(err), 32'd0);
      run_instr(4'b1111, 1'b0, 0, 0);   // recovery after reset

      step();
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
